activation_quantizer: RTL and testbench

Downstream stage of the accumulator: takes the two signed 32-bit column sums it emits and produces int8 activations for the unified-buffer write port. Bias add, optional ReLU, fixed-point requantization (multiply, shift, zero-point) and int8 saturation run in a 3-stage pipeline. A small output FIFO absorbs unified-buffer backpressure, because the accumulator has no ready input.

---
 rtl/activation_quantizer_pkg.sv | 33 +++
 rtl/activation_quantizer_if.sv | 9 +
 rtl/activation_quantizer_out_fifo.sv | 73 +++++++
 rtl/activation_quantizer.sv | 106 ++++++++++
 tb/tb_activation_quantizer.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/activation_quantizer_pkg.sv
// Shared widths, int8 limits, per-column stage record and saturation helpers
// for the activation quantizer.
package act_pkg;

  localparam int ACC_W  = 32;
  localparam int PROD_W = 48;
  localparam int OUT_W  = 8;

  localparam logic signed [OUT_W-1:0] INT8_MIN = -8'sd128;
  localparam logic signed [OUT_W-1:0] INT8_MAX = 8'sd127;

  // One record per column; each field belongs to the stage that writes it.
  typedef struct packed {
    logic [ACC_W-1:0]  sum;
    logic [PROD_W-1:0] prod;
    logic [OUT_W-1:0]  q;
  } col_stage_t;

  function automatic logic [ACC_W-1:0] sat32(input logic signed [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1])
      return v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return v[ACC_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] sat8(input logic signed [PROD_W:0] v);
    if (v > 49'sd127)
      return INT8_MAX;
    if (v < -49'sd128)
      return INT8_MIN;
    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/activation_quantizer_if.sv
// Unified-buffer write port of the activation quantizer (valid/ready + data).
interface activation_quantizer_if;
  logic        ub_wr_valid;
  logic        ub_wr_ready;
  logic [15:0] ub_wr_data;

  modport master (output ub_wr_valid, output ub_wr_data, input ub_wr_ready);
  modport slave  (input ub_wr_valid, input ub_wr_data, output ub_wr_ready);
endinterface

// File: rtl/activation_quantizer_out_fifo.sv
// Output FIFO for the activation quantizer; flags a dropped push when full
// and not popping. Read data holds the last popped word while empty.
module act_out_fifo
  import act_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 2 * OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              wr_en, rd_en;

  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign dout  = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    drop     = push && full && !rd_en;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/activation_quantizer.sv
// Bias / ReLU / requantize / int8-saturate pipeline feeding an output FIFO.
// Define ACTIVATION_ROUNDING_EN for round-half-up before the right shift.
module activation_quantizer
  import act_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [ACC_W-1:0]   acc_col0_in,
  input  logic [ACC_W-1:0]   acc_col1_in,
  input  logic [ACC_W-1:0]   bias_col0,
  input  logic [ACC_W-1:0]   bias_col1,
  input  logic [15:0]        scale,
  input  logic [4:0]         shift,
  input  logic [OUT_W-1:0]   zero_point,
  input  logic               relu_en,
  input  logic               clear_overflow,
  activation_quantizer_if.master ub,
  output logic               busy,
  output logic               overflow
);

  logic [1:0][ACC_W-1:0] acc_w, bias_w;
  logic [1:0][OUT_W-1:0] q_col;
  logic [2:0]            vld_q, vld_d;
  logic                  overflow_q, overflow_d;
  logic                  fifo_empty, fifo_full, fifo_drop, fifo_pop;
  logic [2*OUT_W-1:0]    fifo_dout;

  assign acc_w  = {acc_col1_in, acc_col0_in};
  assign bias_w = {bias_col1, bias_col0};

  for (genvar c = 0; c < 2; c++) begin : g_col
    col_stage_t               st_q, st_d;
    logic signed [ACC_W:0]    sum_ext;
    logic        [ACC_W-1:0]  relu_v;
    logic signed [PROD_W:0]   prod_full, rnd_v, shifted, biased;

    always_comb begin
      st_d      = st_q;
      sum_ext   = {acc_w[c][ACC_W-1], acc_w[c]} + {bias_w[c][ACC_W-1], bias_w[c]};
      st_d.sum  = sat32(sum_ext);

      relu_v    = (relu_en && st_q.sum[ACC_W-1]) ? '0 : st_q.sum;
      prod_full = $signed({{(PROD_W+1-ACC_W){relu_v[ACC_W-1]}}, relu_v})
                * $signed({{(PROD_W+1-16){1'b0}}, scale});
      st_d.prod = prod_full[PROD_W-1:0];

`ifdef ACTIVATION_ROUNDING_EN
      rnd_v     = (shift != '0) ? $signed({{PROD_W{1'b0}}, 1'b1} << (shift - 5'd1)) : '0;
`else
      rnd_v     = '0;
`endif
      shifted   = ($signed({st_q.prod[PROD_W-1], st_q.prod}) + rnd_v) >>> shift;
      biased    = shifted + $signed({{(PROD_W+1-OUT_W){zero_point[OUT_W-1]}}, zero_point});
      st_d.q    = sat8(biased);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) st_q <= '0;
      else        st_q <= st_d;
    end

    assign q_col[c] = st_q.q;
  end

  assign fifo_pop = !fifo_empty && ub.ub_wr_ready;

  always_comb begin
    vld_d      = {vld_q[1:0], valid_in};
    overflow_d = fifo_drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      overflow_q <= overflow_d;
    end
  end

  act_out_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (2 * OUT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_q[2]),
    .din   (q_col),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign ub.ub_wr_valid = !fifo_empty;
  assign ub.ub_wr_data  = fifo_dout;
  assign busy           = (|vld_q) || !fifo_empty;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_activation_quantizer.sv
// Self-checking bench for activation_quantizer against an integer reference model.
module tb_activation_quantizer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] acc0, acc1, bias0, bias1;
  logic [15:0] scale;
  logic [4:0]  shift;
  logic [7:0]  zp;
  logic        relu_en, clear_overflow;
  logic        busy, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  activation_quantizer_if ub_if ();

  activation_quantizer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .acc_col0_in    (acc0),
    .acc_col1_in    (acc1),
    .bias_col0      (bias0),
    .bias_col1      (bias1),
    .scale          (scale),
    .shift          (shift),
    .zero_point     (zp),
    .relu_en        (relu_en),
    .clear_overflow (clear_overflow),
    .ub             (ub_if),
    .busy           (busy),
    .overflow       (overflow)
  );

  // Reference: plain 64-bit integer arithmetic following the quantization rules.
  function automatic logic [7:0] ref_col(input logic [31:0] acc, input logic [31:0] bias);
    longint s, p;
    logic [63:0] r;
    s = longint'($signed(acc)) + longint'($signed(bias));
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    if (relu_en && s < 0) s = 0;
    p = s * longint'(scale);
`ifdef ACTIVATION_ROUNDING_EN
    if (shift != 0) p = p + (longint'(1) <<< (shift - 1));
`endif
    p = p >>> shift;
    p = p + longint'($signed(zp));
    if (p > 127)  p = 127;
    if (p < -128) p = -128;
    r = p;
    return r[7:0];
  endfunction

  function automatic logic [15:0] ref_word(input logic [31:0] a0, input logic [31:0] a1);
    return {ref_col(a1, bias1), ref_col(a0, bias0)};
  endfunction

  task automatic set_cfg(input logic [31:0] b0, input logic [31:0] b1, input logic [15:0] sc,
                         input logic [4:0] sh, input logic [7:0] z, input logic re);
    bias0 = b0; bias1 = b1; scale = sc; shift = sh; zp = z; relu_en = re;
  endtask

  // One transaction with ready high; returns the first word seen and its latency in cycles.
  task automatic send_get(input logic [31:0] a0, input logic [31:0] a1,
                          output logic [15:0] d, output int lat);
    ub_if.ub_wr_ready = 1'b1;
    @(negedge clk);
    valid_in = 1'b1; acc0 = a0; acc1 = a1;
    lat = -1; d = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (ub_if.ub_wr_valid && lat < 0) begin
        lat = i;
        d   = ub_if.ub_wr_data;
      end
    end
  endtask

  task automatic drain;
    int i;
    ub_if.ub_wr_ready = 1'b1;
    valid_in = 1'b0;
    i = 0;
    while (busy && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    n_checks += 4;
    if (ub_if.ub_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ub_if.ub_wr_valid); end
    if (ub_if.ub_wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", ub_if.ub_wr_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough;
    logic [15:0] exp;
    set_cfg(32'd0, 32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
    exp = ref_word(32'd100, -32'sd50);
    ub_if.ub_wr_ready = 1'b1;
    @(negedge clk);
    valid_in = 1'b1; acc0 = 32'd100; acc1 = -32'sd50;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      n_checks++;
      if (ub_if.ub_wr_valid !== (i == 3)) begin
        n_fail++; $display("FAIL pass_latency cycle %0d valid=%b want %b", i, ub_if.ub_wr_valid, (i == 3));
      end
    end
    n_checks++;
    if (ub_if.ub_wr_data !== exp) begin n_fail++; $display("FAIL pass_data got %h want %h", ub_if.ub_wr_data, exp); end
    drain();
  endtask

  task automatic test_relu;
    logic [15:0] d; int lat;
    set_cfg(32'd0, 32'd0, 16'd1, 5'd0, 8'd0, 1'b1);
    send_get(32'd100, -32'sd50, d, lat);
    n_checks += 2;
    if (d !== ref_word(32'd100, -32'sd50)) begin n_fail++; $display("FAIL relu_data got %h want %h", d, ref_word(32'd100, -32'sd50)); end
    if (lat !== 3) begin n_fail++; $display("FAIL relu_latency got %0d want 3", lat); end
    set_cfg(-32'sd150, 32'd0, 16'd1, 5'd0, 8'd0, 1'b1);
    send_get(32'd100, -32'sd50, d, lat);
    n_checks++;
    if (d !== ref_word(32'd100, -32'sd50)) begin n_fail++; $display("FAIL relu_bias got %h want %h", d, ref_word(32'd100, -32'sd50)); end
  endtask

  task automatic test_scaling;
    logic [15:0] d; int lat;
    set_cfg(32'd0, 32'd0, 16'd3, 5'd2, 8'd0, 1'b0);
    send_get(32'd5, -32'sd5, d, lat);
    n_checks++;
    if (d !== ref_word(32'd5, -32'sd5)) begin n_fail++; $display("FAIL scale_pm5 got %h want %h", d, ref_word(32'd5, -32'sd5)); end
    set_cfg(32'd0, 32'd0, 16'd3, 5'd2, 8'd10, 1'b0);
    send_get(-32'sd5, 32'd7, d, lat);
    n_checks++;
    if (d !== ref_word(-32'sd5, 32'd7)) begin n_fail++; $display("FAIL scale_zp got %h want %h", d, ref_word(-32'sd5, 32'd7)); end
    set_cfg(32'd0, 32'd0, 16'd1, 5'd1, 8'hF6, 1'b0);
    send_get(32'd3, -32'sd3, d, lat);
    n_checks++;
    if (d !== ref_word(32'd3, -32'sd3)) begin n_fail++; $display("FAIL scale_half got %h want %h", d, ref_word(32'd3, -32'sd3)); end
  endtask

  task automatic test_saturation;
    logic [15:0] d; int lat;
    set_cfg(32'd1, 32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
    send_get(32'h7FFF_FFFF, -32'sd1000, d, lat);
    n_checks++;
    if (d !== ref_word(32'h7FFF_FFFF, -32'sd1000)) begin n_fail++; $display("FAIL sat_pos got %h want %h", d, ref_word(32'h7FFF_FFFF, -32'sd1000)); end
    set_cfg(32'hFFFF_FFFF, 32'h7FFF_FFFF, 16'hFFFF, 5'd31, 8'd0, 1'b0);
    send_get(32'h8000_0000, 32'h7FFF_FFFF, d, lat);
    n_checks++;
    if (d !== ref_word(32'h8000_0000, 32'h7FFF_FFFF)) begin n_fail++; $display("FAIL sat_wide got %h want %h", d, ref_word(32'h8000_0000, 32'h7FFF_FFFF)); end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 4000)) - 32'd2000;
      default: return 32'($urandom_range(0, 300)) - 32'd150;
    endcase
  endfunction

  task automatic test_random;
    logic [15:0] q[$];
    logic [31:0] a0, a1;
    int i;
    for (int b = 0; b < 4; b++) begin
      drain();
      set_cfg(rand_val(), rand_val(), 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 40)),
              5'($urandom_range(0, 31)), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) shift = 5'($urandom_range(0, 6));
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        ub_if.ub_wr_ready = ($urandom_range(0, 3) != 0);
        if (ub_if.ub_wr_valid && ub_if.ub_wr_ready) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++; $display("FAIL rand_extra got %h want none", ub_if.ub_wr_data);
          end else begin
            if (ub_if.ub_wr_data !== q[0]) begin n_fail++; $display("FAIL rand_data got %h want %h", ub_if.ub_wr_data, q[0]); end
            void'(q.pop_front());
          end
        end
        if (q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
          a0 = rand_val(); a1 = rand_val();
          valid_in = 1'b1; acc0 = a0; acc1 = a1;
          q.push_back(ref_word(a0, a1));
        end else begin
          valid_in = 1'b0;
        end
      end
      @(negedge clk);
      valid_in = 1'b0;
      ub_if.ub_wr_ready = 1'b1;
      i = 0;
      while (q.size() != 0 && i < 40) begin
        if (ub_if.ub_wr_valid) begin
          n_checks++;
          if (ub_if.ub_wr_data !== q[0]) begin n_fail++; $display("FAIL rand_drain got %h want %h", ub_if.ub_wr_data, q[0]); end
          void'(q.pop_front());
        end
        @(negedge clk);
        i++;
      end
      n_checks += 2;
      if (q.size() != 0) begin n_fail++; $display("FAIL rand_missing left %0d want 0", q.size()); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow got %b want 0", overflow); end
    end
    drain();
  endtask

  task automatic test_backpressure;
    set_cfg(32'd0, 32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
    ub_if.ub_wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid_in = 1'b1; acc0 = 32'(i + 1); acc1 = 32'd0;
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (6) @(negedge clk);
    n_checks += 3;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b want 1", overflow); end
    if (ub_if.ub_wr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", ub_if.ub_wr_valid); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy got %b want 1", busy); end
    ub_if.ub_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (!ub_if.ub_wr_valid || ub_if.ub_wr_data !== ref_word(32'(i + 1), 32'd0)) begin
        n_fail++; $display("FAIL bp_order idx %0d got v=%b %h want %h", i, ub_if.ub_wr_valid, ub_if.ub_wr_data, ref_word(32'(i + 1), 32'd0));
      end
      @(negedge clk);
    end
    n_checks += 4;
    if (ub_if.ub_wr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", ub_if.ub_wr_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_fall got %b want 0", busy); end
    if (ub_if.ub_wr_data !== ref_word(32'd4, 32'd0)) begin n_fail++; $display("FAIL bp_hold got %h want %h", ub_if.ub_wr_data, ref_word(32'd4, 32'd0)); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %b want 1", overflow); end
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_clear got %b want 0", overflow); end
  endtask

  // FIFO full while the fifth result arrives in the same cycle as a pop.
  task automatic test_full_pop;
    int nxt;
    set_cfg(32'd0, 32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
    nxt = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      valid_in = (i < 5); acc0 = 32'(i + 1); acc1 = 32'd0;
      ub_if.ub_wr_ready = (i >= 7);
      if (ub_if.ub_wr_valid && ub_if.ub_wr_ready) begin
        n_checks++;
        if (ub_if.ub_wr_data !== ref_word(32'(nxt), 32'd0)) begin
          n_fail++; $display("FAIL fullpop_data got %h want %h", ub_if.ub_wr_data, ref_word(32'(nxt), 32'd0));
        end
        nxt++;
      end
    end
    n_checks += 2;
    if (nxt !== 6) begin n_fail++; $display("FAIL fullpop_count got %0d want 5", nxt - 1); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
    drain();
  endtask

  task automatic test_reset_midstream;
    int pops, first;
    logic [15:0] seen;
    set_cfg(32'd0, 32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
    ub_if.ub_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_in = 1'b1; acc0 = 32'(i + 1); acc1 = 32'd9;
    end
    @(negedge clk);
    valid_in = 1'b0;
    reset = 1'b0;
    #1;
    n_checks += 4;
    if (ub_if.ub_wr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", ub_if.ub_wr_valid); end
    if (ub_if.ub_wr_data !== 16'h0) begin n_fail++; $display("FAIL mid_data got %h want 0000", ub_if.ub_wr_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow got %b want 0", overflow); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ub_if.ub_wr_ready = 1'b1;
    valid_in = 1'b1; acc0 = 32'd77; acc1 = -32'sd3;
    pops = 0; first = -1; seen = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (ub_if.ub_wr_valid) begin
        if (first < 0) begin first = i; seen = ub_if.ub_wr_data; end
        pops++;
      end
    end
    n_checks += 3;
    if (pops !== 1) begin n_fail++; $display("FAIL mid_pops got %0d want 1", pops); end
    if (first !== 3) begin n_fail++; $display("FAIL mid_latency got %0d want 3", first); end
    if (seen !== ref_word(32'd77, -32'sd3)) begin n_fail++; $display("FAIL mid_result got %h want %h", seen, ref_word(32'd77, -32'sd3)); end
  endtask

  initial begin
    valid_in = 1'b0; acc0 = '0; acc1 = '0; clear_overflow = 1'b0;
    ub_if.ub_wr_ready = 1'b0;
    set_cfg(32'd0, 32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
    test_reset();
    test_passthrough();
    test_relu();
    test_scaling();
    test_saturation();
    test_random();
    test_backpressure();
    test_full_pop();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
